align_pp_pipe: RTL and testbench

// - Parametrised, handshaked successor to the single-lane partial-product aligner in the MAC subsystem.
// - Accepts NUM_PP denormalised sign-magnitude partial products with their exponents.
// - Finds the group max exponent internally, right-shifts every lane to that exponent,

---
 rtl/align_pp_pipe_pkg.sv | 10 +
 rtl/align_lane.sv | 34 +++
 rtl/align_pp_pipe.sv | 106 ++++++++++
 tb/tb_align_pp_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/align_pp_pipe_pkg.sv
// align_pp_pipe_pkg: shared widths and reset values for the partial-product aligner
package align_pp_pipe_pkg;

    localparam logic RST_VALID = 1'b0;

    function automatic int out_w(input int man_w, input int shift_w);
        return man_w + shift_w + 1;
    endfunction

endpackage

// File: rtl/align_lane.sv
// align_lane: shift one sign-magnitude lane to the group exponent, add sticky, convert to two's complement
module align_lane import align_pp_pipe_pkg::*; #(
    parameter int MAN_W     = 3,
    parameter int EXP_W     = 6,
    parameter int SHIFT_W   = 11,
    parameter int STICKY_EN = 0,
    localparam int OUT_W    = out_w(MAN_W, SHIFT_W)
) (
    input  logic [MAN_W:0]     pp_i,
    input  logic [EXP_W-1:0]   exp_i,
    input  logic [EXP_W-1:0]   max_exp_i,
    output logic [OUT_W-1:0]   align_o
);

    localparam int W = MAN_W + SHIFT_W;

    logic [EXP_W-1:0] diff;
    logic [2*W-1:0]   wide;
    logic [W-1:0]     mag_sh;
    logic             sticky;
    logic             gone;

    // Upper half of the wide shift is the aligned magnitude, lower half holds the bits shifted past the LSB
    always_comb begin
        diff    = max_exp_i - exp_i;
        gone    = int'(diff) > W - 1;
        wide    = {pp_i[MAN_W-1:0], {SHIFT_W{1'b0}}, {W{1'b0}}} >> diff;
        mag_sh  = gone ? '0 : wide[2*W-1:W];
        sticky  = gone ? |pp_i[MAN_W-1:0] : |wide[W-1:0];
        mag_sh[0] = mag_sh[0] | ((STICKY_EN != 0) && sticky);
        align_o = pp_i[MAN_W] ? ~{1'b0, mag_sh} + OUT_W'(1) : {1'b0, mag_sh};
    end

endmodule

// File: rtl/align_pp_pipe.sv
// align_pp_pipe: two-stage handshaked group aligner feeding the adder tree
module align_pp_pipe import align_pp_pipe_pkg::*; #(
    parameter int NUM_PP    = 4,
    parameter int MAN_W     = 3,
    parameter int EXP_W     = 6,
    parameter int SHIFT_W   = 11,
    parameter int STICKY_EN = 0,
    parameter int QF_W      = 5,
    localparam int OUT_W    = out_w(MAN_W, SHIFT_W)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [NUM_PP*(MAN_W+1)-1:0] i_pp,
    input  logic [NUM_PP*EXP_W-1:0]     i_exp,
    input  logic [QF_W-1:0]             i_Q_frac,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [NUM_PP*OUT_W-1:0]     o_align_pp,
    output logic [EXP_W-1:0]            o_max_exp,
    output logic [QF_W-1:0]             o_Q_frac
);

    localparam int PW = MAN_W + 1;
    localparam int LV = $clog2(NUM_PP);
    localparam int N2 = 1 << LV;

    logic                    s1v_q, s1v_d, s2v_q, s2v_d;
    logic                    s1_ld, s2_ld;
    logic [NUM_PP*PW-1:0]    pp_q;
    logic [NUM_PP*EXP_W-1:0] exp_q;
    logic [QF_W-1:0]         qf1_q, qf2_q;
    logic [EXP_W-1:0]        mx1_q, mx2_q;
    logic [NUM_PP*OUT_W-1:0] align_q, align_d;
    logic [EXP_W-1:0]        tree [1:2*N2-1];

    // Heap-ordered max tree; zero-magnitude lanes enter as exponent 0 so an all-zero group yields 0
    always_comb begin
        for (int i = N2; i < 2 * N2; i++) tree[i] = '0;
        for (int i = 0; i < NUM_PP; i++)
            tree[N2+i] = |i_pp[i*PW +: MAN_W] ? i_exp[i*EXP_W +: EXP_W] : '0;
        for (int i = N2 - 1; i >= 1; i--)
            tree[i] = tree[2*i] > tree[2*i+1] ? tree[2*i] : tree[2*i+1];
    end

    for (genvar k = 0; k < NUM_PP; k++) begin : g_lane
        align_lane #(
            .MAN_W(MAN_W), .EXP_W(EXP_W), .SHIFT_W(SHIFT_W), .STICKY_EN(STICKY_EN)
        ) u_lane (
            .pp_i(pp_q[k*PW +: PW]),
            .exp_i(exp_q[k*EXP_W +: EXP_W]),
            .max_exp_i(mx1_q),
            .align_o(align_d[k*OUT_W +: OUT_W])
        );
    end

    // Per-stage advance: a stage loads when it is empty or its contents move on this cycle
    always_comb begin
        s2_ld   = !s2v_q || i_ready;
        s1_ld   = !s1v_q || s2_ld;
        s1v_d   = s1_ld ? i_valid : s1v_q;
        s2v_d   = s2_ld ? s1v_q : s2v_q;
        o_ready = s1_ld;
    end

    // Stage valid flags
    always_ff @(posedge i_clk) begin
        s1v_q <= i_rst ? RST_VALID : s1v_d;
        s2v_q <= i_rst ? RST_VALID : s2v_d;
    end

    // Stage 1 data: raw lanes, exponents, sideband and group max exponent
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pp_q  <= '0;
            exp_q <= '0;
            qf1_q <= '0;
            mx1_q <= '0;
        end else if (s1_ld && i_valid) begin
            pp_q  <= i_pp;
            exp_q <= i_exp;
            qf1_q <= i_Q_frac;
            mx1_q <= tree[1];
        end
    end

    // Stage 2 data: aligned two's-complement lanes held stable while stalled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            align_q <= '0;
            mx2_q   <= '0;
            qf2_q   <= '0;
        end else if (s2_ld && s1v_q) begin
            align_q <= align_d;
            mx2_q   <= mx1_q;
            qf2_q   <= qf1_q;
        end
    end

    assign o_valid    = s2v_q && !i_rst;
    assign o_align_pp = align_q;
    assign o_max_exp  = mx2_q;
    assign o_Q_frac   = qf2_q;

endmodule

// File: tb/tb_align_pp_pipe.sv
// tb_align_pp_pipe: directed and random checks of the aligner pipeline, default and sticky builds
module tb_align_pp_pipe;

    logic        clk = 1'b0;
    logic        rst, iv, ir;
    logic [15:0] pp;
    logic [23:0] ex;
    logic [4:0]  qf;
    logic        ordy, ov, ordy_s, ov_s;
    logic [59:0] al, al_s;
    logic [5:0]  mx, mx_s;
    logic [4:0]  oq, oq_s;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    align_pp_pipe u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(iv), .o_ready(ordy), .i_pp(pp), .i_exp(ex),
        .i_Q_frac(qf), .o_valid(ov), .i_ready(ir), .o_align_pp(al), .o_max_exp(mx), .o_Q_frac(oq)
    );

    align_pp_pipe #(.STICKY_EN(1)) u_sty (
        .i_clk(clk), .i_rst(rst), .i_valid(iv), .o_ready(ordy_s), .i_pp(pp), .i_exp(ex),
        .i_Q_frac(qf), .o_valid(ov_s), .i_ready(ir), .o_align_pp(al_s), .o_max_exp(mx_s), .o_Q_frac(oq_s)
    );

    function automatic logic [59:0] model(input logic [15:0] p, input logic [23:0] e, input bit st,
                                          output logic [5:0] m);
        logic [59:0] r;
        longint      v;
        int          d;
        bit          lost;
        m = '0;
        for (int k = 0; k < 4; k++)
            if (p[k*4 +: 3] != 0 && e[k*6 +: 6] > m) m = e[k*6 +: 6];
        r = '0;
        for (int k = 0; k < 4; k++) begin
            v = longint'(p[k*4 +: 3]) * 2048;
            if (v != 0) begin
                d = int'(m) - int'(e[k*6 +: 6]);
                lost = (d >= 14) ? 1'b1 : ((v % (longint'(1) << d)) != 0);
                v = (d >= 14) ? 0 : (v >> d);
                if (st && lost) v = v | 1;
                if (p[k*4+3]) v = 32768 - v;
            end
            r[k*15 +: 15] = v[14:0];
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; iv = 1'b0; ir = 1'b1; pp = '0; ex = '0; qf = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL rst_ov_during got=%b want=0", ov); end
        rst = 1'b0;
        #1;
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL rst_ov got=%b want=0", ov); end
        total++; if (ordy !== 1'b1) begin bad++; $display("FAIL rst_ordy got=%b want=1", ordy); end
        total++; if (al !== 60'h0) begin bad++; $display("FAIL rst_al got=%h want=0", al); end
        total++; if (mx !== 6'd0) begin bad++; $display("FAIL rst_mx got=%0d want=0", mx); end
        total++; if (oq !== 5'd0) begin bad++; $display("FAIL rst_qf got=%0d want=0", oq); end
    endtask

    task automatic send_and_check(input string nm, input logic [15:0] p, input logic [23:0] e,
                                  input logic [4:0] q, input logic [59:0] w, input logic [59:0] ws,
                                  input logic [5:0] wm);
        pp = p; ex = e; qf = q; iv = 1'b1; ir = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL %s_lat1 got ov=%b want=0", nm, ov); end
        @(posedge clk); #1;
        total++; if (ov !== 1'b1) begin bad++; $display("FAIL %s_lat2 got ov=%b want=1", nm, ov); end
        total++; if (al !== w) begin bad++; $display("FAIL %s_al got=%h want=%h", nm, al, w); end
        total++; if (al_s !== ws) begin bad++; $display("FAIL %s_al_sticky got=%h want=%h", nm, al_s, ws); end
        total++; if (mx !== wm) begin bad++; $display("FAIL %s_mx got=%0d want=%0d", nm, mx, wm); end
        total++; if (mx_s !== wm) begin bad++; $display("FAIL %s_mx_sticky got=%0d want=%0d", nm, mx_s, wm); end
        total++; if (oq !== q) begin bad++; $display("FAIL %s_qf got=%0d want=%0d", nm, oq, q); end
        @(posedge clk); #1;
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL %s_drain got ov=%b want=0", nm, ov); end
    endtask

    task automatic test_basic();
        send_and_check("basic", 16'h0D47, {6'd20, 6'd10, 6'd8, 6'd10}, 5'h15,
                       {15'h0000, 15'h5800, 15'h0800, 15'h3800},
                       {15'h0000, 15'h5800, 15'h0800, 15'h3800}, 6'd10);
    endtask

    task automatic test_diff_bound();
        send_and_check("bound", 16'h5771, {6'd2, 6'd0, 6'd1, 6'd14}, 5'h0A,
                       {15'h0002, 15'h0000, 15'h0001, 15'h0800},
                       {15'h0003, 15'h0001, 15'h0001, 15'h0800}, 6'd14);
    endtask

    task automatic test_zero_group();
        send_and_check("zero", 16'h8888, {6'd33, 6'd12, 6'd7, 6'd50}, 5'h1F,
                       60'h0, 60'h0, 6'd0);
    endtask

    task automatic test_backpressure();
        logic [15:0] gp [5];
        logic [23:0] ge [5];
        logic [4:0]  gq [5];
        logic [59:0] ea, pal;
        logic [5:0]  em, pmx;
        logic [4:0]  pq;
        bit          stl;
        bit          eo;
        int          sent, recv;
        gp = '{16'h1234, 16'h0F7A, 16'hC365, 16'h7777, 16'h9AB3};
        ge = '{{6'd5, 6'd3, 6'd9, 6'd9}, {6'd0, 6'd12, 6'd11, 6'd1}, {6'd7, 6'd7, 6'd2, 6'd30},
               {6'd4, 6'd5, 6'd6, 6'd7}, {6'd20, 6'd19, 6'd8, 6'd1}};
        gq = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
        sent = 0; recv = 0; stl = 1'b0; pal = '0; pmx = '0; pq = '0;
        for (int c = 0; c < 40 && recv < 5; c++) begin
            ir = !(c >= 3 && c <= 5);
            iv = sent < 5;
            if (sent < 5) begin pp = gp[sent]; ex = ge[sent]; qf = gq[sent]; end
            #1;
            eo = (sent - recv < 2) || ir;
            total++; if (ordy !== eo) begin bad++; $display("FAIL bp_ordy c=%0d got=%b want=%b", c, ordy, eo); end
            if (stl) begin
                total++; if (al !== pal || mx !== pmx || oq !== pq)
                    begin bad++; $display("FAIL bp_stable c=%0d got=%h/%0d/%0d want=%h/%0d/%0d", c, al, mx, oq, pal, pmx, pq); end
            end
            if (ov) begin
                ea = model(gp[recv], ge[recv], 1'b0, em);
                total++; if (al !== ea || mx !== em || oq !== gq[recv])
                    begin bad++; $display("FAIL bp_data n=%0d got=%h/%0d/%0d want=%h/%0d/%0d", recv, al, mx, oq, ea, em, gq[recv]); end
            end
            stl = ov && !ir; pal = al; pmx = mx; pq = oq;
            if (ov && ir) recv++;
            if (iv && ordy) sent++;
            @(posedge clk); #1;
        end
        iv = 1'b0; ir = 1'b1;
        total++; if (recv != 5) begin bad++; $display("FAIL bp_count got=%0d want=5", recv); end
        @(posedge clk); #1;
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL bp_extra got ov=%b want=0", ov); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rp [50];
        logic [23:0] re [50];
        logic [4:0]  rq [50];
        logic [59:0] ea;
        logic [5:0]  em;
        bit          ev;
        for (int i = 0; i < 50; i++) begin
            rp[i] = 16'($urandom);
            for (int k = 0; k < 4; k++) re[i][k*6 +: 6] = 6'($urandom_range(0, 20));
            rq[i] = 5'($urandom);
        end
        ir = 1'b1;
        for (int c = 0; c < 52; c++) begin
            iv = c < 50;
            if (c < 50) begin pp = rp[c]; ex = re[c]; qf = rq[c]; end
            #1;
            ev = c >= 2;
            total++; if (ordy !== 1'b1) begin bad++; $display("FAIL b2b_ordy c=%0d got=%b want=1", c, ordy); end
            total++; if (ov !== ev) begin bad++; $display("FAIL b2b_ov c=%0d got=%b want=%b", c, ov, ev); end
            if (ev) begin
                ea = model(rp[c-2], re[c-2], 1'b0, em);
                total++; if (al !== ea || mx !== em || oq !== rq[c-2])
                    begin bad++; $display("FAIL b2b_data c=%0d got=%h/%0d/%0d want=%h/%0d/%0d", c, al, mx, oq, ea, em, rq[c-2]); end
                ea = model(rp[c-2], re[c-2], 1'b1, em);
                total++; if (al_s !== ea || mx_s !== em || oq_s !== rq[c-2] || ov_s !== 1'b1)
                    begin bad++; $display("FAIL b2b_sticky c=%0d got=%h/%0d want=%h/%0d", c, al_s, mx_s, ea, em); end
            end
            @(posedge clk); #1;
        end
        iv = 1'b0;
    endtask

    task automatic test_reset_flight();
        ir = 1'b1;
        iv = 1'b1; pp = 16'h7777; ex = {6'd3, 6'd2, 6'd1, 6'd0}; qf = 5'd9;
        @(posedge clk); #1;
        pp = 16'h1111; ex = {6'd1, 6'd1, 6'd1, 6'd1}; qf = 5'd10;
        @(posedge clk); #1;
        iv = 1'b0; ir = 1'b0; rst = 1'b1;
        #1;
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL rf_ov_during got=%b want=0", ov); end
        @(posedge clk); #1;
        rst = 1'b0; ir = 1'b1;
        #1;
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL rf_ov got=%b want=0", ov); end
        total++; if (al !== 60'h0 || mx !== 6'd0 || oq !== 5'd0)
            begin bad++; $display("FAIL rf_outs got=%h/%0d/%0d want=0/0/0", al, mx, oq); end
        total++; if (ordy !== 1'b1) begin bad++; $display("FAIL rf_ordy got=%b want=1", ordy); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if (ov !== 1'b0) begin bad++; $display("FAIL rf_stale c=%0d got=%b want=0", c, ov); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_diff_bound();
        test_zero_group();
        test_backpressure();
        test_back_to_back();
        test_reset_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
